// File: rtl/sici_pcs_pkg.sv
// rtl/sici_pcs_pkg.sv - shared types, header defaults and sizing helper for the Sici PCS block lock
package sici_pcs_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIPW  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCK   = 2'd3
    } blk_state_t;

    localparam logic [1:0] SH_A_DEF = 2'b01;
    localparam logic [1:0] SH_B_DEF = 2'b10;

    // Bits needed to hold values 0..v-1; callers pass (max+1) so max itself fits.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sici_sat_cnt.sv
// rtl/sici_sat_cnt.sv - saturating event counter with clock enable and synchronous clear
module sici_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (ce) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sici_pcs_blk_lock.sv
// rtl/sici_pcs_blk_lock.sv - receive block synchroniser: header hunt, verify, windowed lock monitor
module sici_pcs_blk_lock
    import sici_pcs_pkg::*;
#(
    parameter int             FW       = 40,
    parameter int             SHW      = 2,
    parameter logic [SHW-1:0] SH_A     = SHW'(SH_A_DEF),
    parameter logic [SHW-1:0] SH_B     = SHW'(SH_B_DEF),
    parameter int             ENT      = 32,
    parameter int             WIN      = 64,
    parameter int             EXT      = 16,
    parameter int             SLP_WAIT = 4,
    parameter int             ECW      = 16
) (
    input  logic           Ck,
    input  logic           Rs,
    input  logic           CE,
    input  logic [FW-1:0]  Phy_Dat,
    input  logic           Re_Syn,
    input  logic           Cnt_Clr,
    output logic           Bit_Slp,
    output logic           Syn_OK,
    output logic           Lo_Syn,
    output logic           Err_SH,
    output logic [FW-1:0]  PCS_Dat,
    output logic [ECW-1:0] Err_Cnt,
    output logic [7:0]     Slp_Cnt
);

    localparam int GW = clog2(ENT + 1);
    localparam int BW = clog2(EXT + 1);
    localparam int WW = clog2(WIN + 1);
    localparam int TW = clog2(SLP_WAIT + 1);

    localparam logic [GW-1:0] ENT_V    = GW'(ENT);
    localparam logic [BW-1:0] EXT_V    = BW'(EXT);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
    localparam logic [TW-1:0] WAIT_V   = TW'(SLP_WAIT);

    blk_state_t    state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [WW-1:0] win_q, win_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          syn_ok_q, syn_ok_d;
    logic          lo_syn_q, lo_syn_d;
    logic          bit_slp_q, bit_slp_d;
    logic          err_sh_q, err_sh_d;
    logic [FW-1:0] pcs_dat_q, pcs_dat_d;

    logic [SHW-1:0] hdr;
    logic           hdr_ok;
    logic           slip;

    assign hdr    = Phy_Dat[FW-1 -: SHW];
    assign hdr_ok = (hdr == SH_A) || (hdr == SH_B);

    // Next-state evaluation of one frame per enabled cycle; a slip from any state funnels through one path.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        win_d     = win_q;
        wait_d    = wait_q;
        syn_ok_d  = syn_ok_q;
        lo_syn_d  = lo_syn_q;
        bit_slp_d = bit_slp_q;
        err_sh_d  = err_sh_q;
        pcs_dat_d = pcs_dat_q;
        slip      = 1'b0;
        if (CE) begin
            pcs_dat_d = Phy_Dat;
            bit_slp_d = 1'b0;
            err_sh_d  = 1'b0;
            if (Re_Syn) begin
                state_d = ST_HUNT;
                good_d  = '0;
                bad_d   = '0;
                win_d   = '0;
                wait_d  = '0;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        if (!hdr_ok) begin
                            slip = 1'b1;
                        end else if (ENT_V == GW'(1)) begin
                            state_d = ST_LOCK;
                            good_d  = '0;
                            bad_d   = '0;
                            win_d   = '0;
                        end else begin
                            state_d = ST_VERIFY;
                            good_d  = GW'(1);
                        end
                    end
                    ST_SLIPW: begin
                        wait_d = wait_q - 1'b1;
                        if (wait_q <= TW'(1)) begin
                            state_d = ST_HUNT;
                            wait_d  = '0;
                        end
                    end
                    ST_VERIFY: begin
                        if (!hdr_ok) begin
                            slip = 1'b1;
                        end else if ((good_q + 1'b1) == ENT_V) begin
                            state_d = ST_LOCK;
                            good_d  = '0;
                            bad_d   = '0;
                            win_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        if (!hdr_ok) begin
                            err_sh_d = 1'b1;
                            if ((bad_q + 1'b1) == EXT_V) begin
                                slip = 1'b1;
                            end else begin
                                bad_d = bad_q + 1'b1;
                            end
                        end
                        if (!slip) begin
                            if (win_q == WIN_LAST) begin
                                win_d = '0;
                                bad_d = '0;
                            end else begin
                                win_d = win_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                    end
                endcase
                if (slip) begin
                    state_d   = ST_SLIPW;
                    bit_slp_d = 1'b1;
                    wait_d    = WAIT_V;
                    good_d    = '0;
                    bad_d     = '0;
                    win_d     = '0;
                end
            end
            syn_ok_d = (state_d == ST_LOCK);
            lo_syn_d = (state_d != ST_LOCK);
        end
    end

    // Lock FSM state, its counters and the registered status/data outputs.
    always_ff @(posedge Ck or posedge Rs) begin
        if (Rs) begin
            state_q   <= ST_HUNT;
            good_q    <= '0;
            bad_q     <= '0;
            win_q     <= '0;
            wait_q    <= '0;
            syn_ok_q  <= 1'b0;
            lo_syn_q  <= 1'b1;
            bit_slp_q <= 1'b0;
            err_sh_q  <= 1'b0;
            pcs_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            win_q     <= win_d;
            wait_q    <= wait_d;
            syn_ok_q  <= syn_ok_d;
            lo_syn_q  <= lo_syn_d;
            bit_slp_q <= bit_slp_d;
            err_sh_q  <= err_sh_d;
            pcs_dat_q <= pcs_dat_d;
        end
    end

    sici_sat_cnt #(.W(ECW)) u_err_cnt (
        .clk (Ck),
        .rst (Rs),
        .ce  (CE),
        .inc (err_sh_d),
        .clr (Cnt_Clr),
        .cnt (Err_Cnt)
    );

    sici_sat_cnt #(.W(8)) u_slp_cnt (
        .clk (Ck),
        .rst (Rs),
        .ce  (CE),
        .inc (bit_slp_d),
        .clr (Cnt_Clr),
        .cnt (Slp_Cnt)
    );

    assign Bit_Slp = bit_slp_q;
    assign Syn_OK  = syn_ok_q;
    assign Lo_Syn  = lo_syn_q;
    assign Err_SH  = err_sh_q;
    assign PCS_Dat = pcs_dat_q;

endmodule

// File: tb/tb_sici_pcs_blk_lock.sv
// tb/tb_sici_pcs_blk_lock.sv - self-checking bench for sici_pcs_blk_lock with a bit-offset SerDes model
module tb_sici_pcs_blk_lock;

    localparam int FW       = 40;
    localparam int ENT      = 32;
    localparam int WIN      = 64;
    localparam int EXT      = 16;
    localparam int SLP_WAIT = 4;

    logic          Ck = 1'b0;
    logic          Rs;
    logic          CE;
    logic [FW-1:0] Phy_Dat;
    logic          Re_Syn;
    logic          Cnt_Clr;

    logic          Bit_Slp, Syn_OK, Lo_Syn, Err_SH;
    logic [FW-1:0] PCS_Dat;
    logic [15:0]   Err_Cnt;
    logic [7:0]    Slp_Cnt;

    logic          Bit_Slp4, Syn_OK4, Lo_Syn4, Err_SH4;
    logic [FW-1:0] PCS_Dat4;
    logic [3:0]    Err_Cnt4;
    logic [7:0]    Slp_Cnt4;

    always #5 Ck = ~Ck;

    sici_pcs_blk_lock #(.ECW(16)) dut (
        .Ck(Ck), .Rs(Rs), .CE(CE), .Phy_Dat(Phy_Dat), .Re_Syn(Re_Syn), .Cnt_Clr(Cnt_Clr),
        .Bit_Slp(Bit_Slp), .Syn_OK(Syn_OK), .Lo_Syn(Lo_Syn), .Err_SH(Err_SH),
        .PCS_Dat(PCS_Dat), .Err_Cnt(Err_Cnt), .Slp_Cnt(Slp_Cnt)
    );

    sici_pcs_blk_lock #(.ECW(4)) dut4 (
        .Ck(Ck), .Rs(Rs), .CE(CE), .Phy_Dat(Phy_Dat), .Re_Syn(Re_Syn), .Cnt_Clr(Cnt_Clr),
        .Bit_Slp(Bit_Slp4), .Syn_OK(Syn_OK4), .Lo_Syn(Lo_Syn4), .Err_SH(Err_SH4),
        .PCS_Dat(PCS_Dat4), .Err_Cnt(Err_Cnt4), .Slp_Cnt(Slp_Cnt4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state (spec-level view: locked flag, hold-off, run length, window by frame index)
    logic          m_locked;
    int            m_hold, m_good, m_frames, m_win_id, m_win_bad;
    int            m_err, m_err4, m_slp;
    logic          e_slp, e_esh;
    logic [FW-1:0] e_pcs;

    int off;
    int ce_cnt;
    int slip_edges[$];

    typedef struct {
        int n; int kind; int re; int clr; int duty3; int realign;
        int e_syn; int e_err; int e_err4; int e_slp;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_hold = 0; m_good = 0; m_frames = 0; m_win_id = 0; m_win_bad = 0;
        m_err = 0; m_err4 = 0; m_slp = 0; e_slp = 1'b0; e_esh = 1'b0; e_pcs = '0;
    endtask

    task automatic model_step(input logic v, input logic re, input logic clr, input logic [FW-1:0] w);
        e_pcs = w;
        e_slp = 1'b0;
        e_esh = 1'b0;
        if (re) begin
            m_locked = 1'b0; m_hold = 0; m_good = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_locked) begin
            if (m_frames / WIN != m_win_id) begin
                m_win_id  = m_frames / WIN;
                m_win_bad = 0;
            end
            m_frames++;
            if (!v) begin
                e_esh = 1'b1;
                m_win_bad++;
                if (m_win_bad == EXT) begin
                    e_slp = 1'b1; m_locked = 1'b0; m_hold = SLP_WAIT; m_good = 0;
                end
            end
        end else if (v) begin
            m_good++;
            if (m_good == ENT) begin
                m_locked = 1'b1; m_good = 0; m_frames = 0; m_win_id = 0; m_win_bad = 0;
            end
        end else begin
            e_slp = 1'b1; m_hold = SLP_WAIT; m_good = 0;
        end
        if (clr) begin
            m_err = 0; m_err4 = 0; m_slp = 0;
        end else begin
            if (e_esh && m_err < 65535) m_err++;
            if (e_esh && m_err4 < 15) m_err4++;
            if (e_slp && m_slp < 255) m_slp++;
        end
    endtask

    // kind 0: valid header; 1: 2'b00; 2: 2'b11. Three bits after the header copy its LSB so offsets 1..3 are invalid.
    function automatic logic [FW-1:0] mk_frame(input int kind);
        logic [63:0]   r;
        logic [1:0]    sh;
        logic [FW-1:0] f;
        r = {$urandom, $urandom};
        case (kind)
            0:       sh = r[63] ? 2'b01 : 2'b10;
            1:       sh = 2'b00;
            default: sh = 2'b11;
        endcase
        f = r[FW-1:0];
        f[FW-1 -: 2] = sh;
        f[FW-3 -: 3] = {3{sh[0]}};
        return f;
    endfunction

    task automatic cmp_all();
        chk("syn_ok",   64'(Syn_OK),   64'(m_locked));
        chk("lo_syn",   64'(Lo_Syn),   64'(!m_locked));
        chk("bit_slp",  64'(Bit_Slp),  64'(e_slp));
        chk("err_sh",   64'(Err_SH),   64'(e_esh));
        chk("pcs_dat",  64'(PCS_Dat),  64'(e_pcs));
        chk("err_cnt",  64'(Err_Cnt),  64'(m_err));
        chk("slp_cnt",  64'(Slp_Cnt),  64'(m_slp));
        chk("err_cnt4", 64'(Err_Cnt4), 64'(m_err4));
        chk("dut4_misc", 64'({Syn_OK4, Lo_Syn4, Bit_Slp4, Err_SH4, Slp_Cnt4}),
            64'({m_locked, !m_locked, e_slp, e_esh, 8'(m_slp)}));
        chk("pcs_dat4", 64'(PCS_Dat4), 64'(e_pcs));
    endtask

    task automatic cyc(input logic ce_v, input logic re_v, input logic clr_v, input int kind);
        logic [2*FW-1:0] cat;
        logic [FW-1:0]   w;
        logic            v;
        @(negedge Ck);
        cat = {mk_frame(kind), mk_frame(0)};
        w = cat[2*FW-1-off -: FW];
        if (!ce_v) w = FW'({$urandom, $urandom});
        CE = ce_v; Re_Syn = re_v; Cnt_Clr = clr_v; Phy_Dat = w;
        @(posedge Ck);
        #1;
        if (ce_v) begin
            v = (w[FW-1 -: 2] == 2'b01) || (w[FW-1 -: 2] == 2'b10);
            model_step(v, re_v, clr_v, w);
            ce_cnt++;
        end
        cmp_all();
        if (ce_v && Bit_Slp) begin
            off = (off + FW - 1) % FW;
            slip_edges.push_back(ce_cnt);
        end
    endtask

    task automatic async_rst(input string tag);
        @(posedge Ck);
        #3;
        Rs = 1'b1;
        #1;
        chk({tag, "_syn_ok"},  64'(Syn_OK),  64'(0));
        chk({tag, "_lo_syn"},  64'(Lo_Syn),  64'(1));
        chk({tag, "_bit_slp"}, 64'(Bit_Slp), 64'(0));
        chk({tag, "_err_sh"},  64'(Err_SH),  64'(0));
        chk({tag, "_err_cnt"}, 64'(Err_Cnt), 64'(0));
        chk({tag, "_slp_cnt"}, 64'(Slp_Cnt), 64'(0));
        chk({tag, "_pcs_dat"}, 64'(PCS_Dat), 64'(0));
        model_reset();
        CE = 1'b0;
        @(negedge Ck);
        Rs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int nsl;
        logic locked_seen;

        Rs = 1'b1; CE = 1'b0; Re_Syn = 1'b0; Cnt_Clr = 1'b0; Phy_Dat = '0;
        off = 3; ce_cnt = 0; rise = -1;
        model_reset();

        //            n   kind re clr d3 ra syn err err4 slp
        tbl[0]  = '{15, 1, 0, 0, 0, 0, 1, 15, 15, 3};
        tbl[1]  = '{49, 0, 0, 0, 0, 0, 1, 15, 15, 3};
        tbl[2]  = '{15, 1, 0, 0, 0, 0, 1, 30, 15, 3};
        tbl[3]  = '{49, 0, 0, 0, 0, 0, 1, 30, 15, 3};
        tbl[4]  = '{16, 1, 0, 0, 0, 0, 0, 46, 15, 4};
        tbl[5]  = '{35, 0, 0, 0, 0, 1, 0, 46, 15, 4};
        tbl[6]  = '{ 1, 0, 0, 0, 0, 0, 1, 46, 15, 4};
        tbl[7]  = '{ 1, 0, 1, 0, 0, 0, 0, 46, 15, 4};
        tbl[8]  = '{31, 0, 0, 0, 0, 0, 0, 46, 15, 4};
        tbl[9]  = '{ 1, 0, 0, 0, 0, 0, 1, 46, 15, 4};
        tbl[10] = '{ 1, 0, 1, 0, 1, 0, 0, 46, 15, 4};
        tbl[11] = '{31, 0, 0, 0, 1, 0, 0, 46, 15, 4};
        tbl[12] = '{ 1, 0, 0, 0, 1, 0, 1, 46, 15, 4};
        tbl[13] = '{ 1, 1, 0, 1, 0, 0, 1,  0,  0, 0};
        tbl[14] = '{ 3, 1, 0, 0, 0, 0, 1,  3,  3, 0};

        // reset state
        repeat (2) @(posedge Ck);
        #1;
        cmp_all();
        @(negedge Ck);
        Rs = 1'b0;

        // hunt from a 3-bit offset
        slip_edges.delete();
        locked_seen = 1'b0;
        for (int i = 0; i < 300 && !locked_seen; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0);
            if (Syn_OK) begin
                locked_seen = 1'b1;
                rise = ce_cnt;
            end
        end
        chk("hunt_locked", 64'(locked_seen), 64'(1));
        nsl = slip_edges.size();
        chk("hunt_slips", 64'(nsl), 64'(3));
        chk("hunt_slp_cnt", 64'(Slp_Cnt), 64'(3));
        chk("hunt_offset", 64'(off), 64'(0));
        if (nsl == 3) begin
            chk("slip_gap1", 64'(slip_edges[1] - slip_edges[0] >= 5), 64'(1));
            chk("slip_gap2", 64'(slip_edges[2] - slip_edges[1] >= 5), 64'(1));
            chk("lock_latency", 64'(rise - slip_edges[2]), 64'(SLP_WAIT + ENT));
        end

        // table-driven window / re-sync / counter sequences
        for (int r = 0; r < 15; r++) begin
            if (tbl[r].realign != 0) off = 0;
            for (int i = 0; i < tbl[r].n; i++) begin
                int kind;
                kind = (tbl[r].kind == 1) ? 1 + (i % 2) : 0;
                if (tbl[r].duty3 != 0) begin
                    repeat (2) cyc(1'b0, 1'($urandom % 2), 1'($urandom % 2), 0);
                end
                cyc(1'b1, tbl[r].re != 0 && i == 0, tbl[r].clr != 0 && i == 0, kind);
            end
            chk($sformatf("vec%0d_syn", r),  64'(Syn_OK),   64'(tbl[r].e_syn));
            chk($sformatf("vec%0d_err", r),  64'(Err_Cnt),  64'(tbl[r].e_err));
            chk($sformatf("vec%0d_err4", r), 64'(Err_Cnt4), 64'(tbl[r].e_err4));
            chk($sformatf("vec%0d_slp", r),  64'(Slp_Cnt),  64'(tbl[r].e_slp));
        end

        // asynchronous reset while locked, then while in slip hold-off
        async_rst("rst_lock");
        off = 1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("pre_rst_slip", 64'(Bit_Slp), 64'(1));
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 0);
        async_rst("rst_slipw");
        repeat (ENT) cyc(1'b1, 1'b0, 1'b0, 0);
        chk("relock_after_rst", 64'(Syn_OK), 64'(1));

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            int thr;
            int kind;
            case ((i / 300) % 4)
                0:       thr = 0;
                1:       thr = 1;
                2:       thr = 4;
                default: thr = 8;
            endcase
            kind = (int'($urandom % 16) < thr) ? 1 + int'($urandom % 2) : 0;
            if (($urandom % 250) == 0) off = 0;
            cyc(1'(($urandom % 4) != 0), 1'(($urandom % 200) == 0), 1'(($urandom % 100) == 0), kind);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
